command_executor: RTL and testbench

// - Sequences one decoded UART command into a single-port RAM access, then returns a response frame through the UART transmitter.
// - Sits between command_decoder (upstream, done/error/address/data) and the RAM and uart_tx (downstream).
// - Owns the RAM port exclusively; processes one command at a time.

---
 rtl/command_executor_pkg.sv | 32 +++
 rtl/command_executor_if.sv | 38 +++
 rtl/response_serializer.sv | 89 ++++++++
 rtl/command_executor.sv | 122 ++++++++++++
 tb/tb_command_executor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/command_executor_pkg.sv
// rtl/command_executor_pkg.sv - shared state encodings, status bytes and command codes
package command_executor_pkg;

   localparam int DEF_ADDR_WIDTH   = 15;
   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_READ_LATENCY = 2;
   localparam int DEF_TX_TIMEOUT   = 5000;

   typedef enum logic [2:0] {
      IDLE,
      MEM_WRITE,
      MEM_READ,
      READ_WAIT,
      TX_STATUS,
      TX_WAIT,
      TX_DATA,
      DONE
   } state_t;

   localparam logic [7:0] STAT_WR_OK = 8'h00;
   localparam logic [7:0] STAT_RD_OK = 8'h01;
   localparam logic [7:0] STAT_ERR   = 8'hE0;

   // Shared with command_decoder
   localparam logic [7:0] CMD_WRITE = 8'h00;
   localparam logic [7:0] CMD_READ  = 8'h01;

   function automatic logic [7:0] err_status(input logic [1:0] code);
      return STAT_ERR | {6'b0, code};
   endfunction

endpackage

// File: rtl/command_executor_if.sv
// rtl/command_executor_if.sv - decoder, RAM and uart_tx signals around the executor
interface command_executor_if #(
   parameter int ADDR_WIDTH = command_executor_pkg::DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = command_executor_pkg::DEF_DATA_WIDTH
);
   logic                  cmd_done;
   logic                  cmd_rw;
   logic [ADDR_WIDTH-1:0] cmd_address;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic [1:0]            cmd_error;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   logic                  tx_start;
   logic [7:0]            tx_byte;
   logic                  tx_busy;
   logic                  tx_done;

   modport master (
      input  cmd_done, cmd_rw, cmd_address, cmd_data, cmd_error,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output tx_start, tx_byte,
      input  tx_busy, tx_done
   );

   modport slave (
      output cmd_done, cmd_rw, cmd_address, cmd_data, cmd_error,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  tx_start, tx_byte,
      output tx_busy, tx_done
   );
endinterface

// File: rtl/response_serializer.sv
// rtl/response_serializer.sv - sends status byte plus optional data word LSB first over uart_tx
module response_serializer
   import command_executor_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            status,
   input  logic                  has_data,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  tx_start,
   output logic [7:0]            tx_byte,
   input  logic                  tx_busy,
   input  logic                  tx_done,
   output logic                  done
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(NBYTES + 1);
   localparam int TMR_W  = $clog2(TX_TIMEOUT + 1);

   state_t                state;
   logic [7:0]            status_q;
   logic [DATA_WIDTH-1:0] word;
   logic                  with_data;
   logic [IDX_W-1:0]      idx;
   logic [TMR_W-1:0]      tmr;
   logic                  more;

   assign more = with_data && (idx < IDX_W'(NBYTES));
   // Finishes on the last tx_done, or when the tx_done wait overruns and the frame is abandoned
   assign done = (state == TX_WAIT) && (tx_done ? !more : (tmr == TMR_W'(TX_TIMEOUT)));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         tx_start  <= 1'b0;
         tx_byte   <= '0;
         status_q  <= '0;
         word      <= '0;
         with_data <= 1'b0;
         idx       <= '0;
         tmr       <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: if (start) begin
               status_q  <= status;
               word      <= data;
               with_data <= has_data;
               idx       <= '0;
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_byte  <= status;
                  tmr      <= '0;
                  state    <= TX_WAIT;
               end else begin
                  state <= TX_STATUS;
               end
            end
            TX_STATUS: if (!tx_busy) begin
               tx_start <= 1'b1;
               tx_byte  <= status_q;
               tmr      <= '0;
               state    <= TX_WAIT;
            end
            TX_WAIT: begin
               if (tx_done)
                  state <= more ? TX_DATA : IDLE;
               else if (tmr == TMR_W'(TX_TIMEOUT))
                  state <= IDLE;
               else
                  tmr <= tmr + TMR_W'(1);
            end
            TX_DATA: if (!tx_busy) begin
               tx_start <= 1'b1;
               tx_byte  <= word[7:0];
               word     <= word >> 8;
               idx      <= idx + IDX_W'(1);
               tmr      <= '0;
               state    <= TX_WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/command_executor.sv
// rtl/command_executor.sv - runs one decoded command against the RAM and returns its response frame
module command_executor
   import command_executor_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter int TX_TIMEOUT   = DEF_TX_TIMEOUT
) (
   input  logic                clock,
   input  logic                reset,
   command_executor_if.master  bus,
   output logic                o_busy,
   output logic [7:0]          o_drop_count
);
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   state_t                state;
   logic [LAT_W-1:0]      lat_cnt;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [7:0]            status_q;
   logic                  with_data;
   logic                  ser_start;
   logic                  ser_done;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         lat_cnt       <= '0;
         rdata_q       <= '0;
         status_q      <= '0;
         with_data     <= 1'b0;
         ser_start     <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         o_busy        <= 1'b0;
         o_drop_count  <= '0;
      end else begin
         bus.mem_en <= 1'b0;
         bus.mem_we <= 1'b0;
         ser_start  <= 1'b0;
         // DONE counts as busy, so a command arriving on the DONE->IDLE edge is dropped
         if (bus.cmd_done && state != IDLE && o_drop_count != 8'hFF)
            o_drop_count <= o_drop_count + 8'd1;
         case (state)
            IDLE: if (bus.cmd_done) begin
               bus.mem_addr  <= ADDR_WIDTH'(bus.cmd_address);
               bus.mem_wdata <= bus.cmd_data;
               with_data     <= 1'b0;
               o_busy        <= 1'b1;
               if (bus.cmd_error != 2'b00) begin
                  status_q  <= err_status(bus.cmd_error);
                  ser_start <= 1'b1;
                  state     <= TX_STATUS;
               end else begin
                  case ({7'b0, bus.cmd_rw})
                     CMD_WRITE: begin
                        bus.mem_en <= 1'b1;
                        bus.mem_we <= 1'b1;
                        state      <= MEM_WRITE;
                     end
                     CMD_READ: begin
                        bus.mem_en <= 1'b1;
                        state      <= MEM_READ;
                     end
                     default: state <= IDLE;
                  endcase
               end
            end
            MEM_WRITE: begin
               status_q  <= STAT_WR_OK;
               ser_start <= 1'b1;
               state     <= TX_STATUS;
            end
            MEM_READ: begin
               lat_cnt <= '0;
               state   <= READ_WAIT;
            end
            READ_WAIT: begin
               if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                  rdata_q   <= bus.mem_rdata;
                  status_q  <= STAT_RD_OK;
                  with_data <= 1'b1;
                  ser_start <= 1'b1;
                  state     <= TX_STATUS;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            // The serializer owns TX_STATUS/TX_WAIT/TX_DATA; here we only wait for it
            TX_STATUS: if (ser_done) state <= DONE;
            DONE: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   response_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .TX_TIMEOUT (TX_TIMEOUT)
   ) u_serializer (
      .clock    (clock),
      .reset    (reset),
      .start    (ser_start),
      .status   (status_q),
      .has_data (with_data),
      .data     (rdata_q),
      .tx_start (bus.tx_start),
      .tx_byte  (bus.tx_byte),
      .tx_busy  (bus.tx_busy),
      .tx_done  (bus.tx_done),
      .done     (ser_done)
   );
endmodule

// File: tb/tb_command_executor.sv
// tb/tb_command_executor.sv - scoreboard bench for command_executor with RAM and uart_tx models
module tb_command_executor;
   import command_executor_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       busy;
   logic [7:0] drop_count;

   always #5 clock = ~clock;

   command_executor_if #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .DATA_WIDTH(DEF_DATA_WIDTH)) bus ();

   command_executor dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .o_busy       (busy),
      .o_drop_count (drop_count)
   );

   typedef struct {
      logic        we;
      logic [14:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   mem_exp_t   exp_mem[$];
   logic [7:0] exp_tx[$];
   mem_exp_t   mon_m;
   logic [7:0] mon_b;
   int         n_checks = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         tx_seen = 0;
   logic       force_busy = 1'b0;
   logic       mute = 1'b0;
   int         uart_cnt = 0;
   logic [31:0] ram [0:32767];
   logic [31:0] rd_stage = '0;
   logic        rd_valid = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic expect_mem(input logic we, input logic [14:0] a, input logic [31:0] d);
      mem_exp_t m;
      m.we = we; m.addr = a; m.wdata = d;
      exp_mem.push_back(m);
   endtask

   // uart_tx model: busy for 4 cycles per byte, then tx_done unless muted
   always @(posedge clock) begin
      bus.tx_done <= 1'b0;
      if (!reset) begin
         uart_cnt    <= 0;
         bus.tx_busy <= force_busy;
      end else if (uart_cnt != 0) begin
         uart_cnt <= uart_cnt - 1;
         if (uart_cnt == 1) begin
            bus.tx_busy <= force_busy;
            bus.tx_done <= !mute;
         end
      end else if (bus.tx_start) begin
         bus.tx_busy <= 1'b1;
         uart_cnt    <= 4;
      end else begin
         bus.tx_busy <= force_busy;
      end
   end

   // RAM model, two register stages; rdata is junk outside the single valid cycle
   always @(posedge clock) begin
      rd_valid      <= 1'b0;
      bus.mem_rdata <= rd_valid ? rd_stage : 32'h0BAD_F00D;
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else begin
            rd_stage <= ram[bus.mem_addr];
            rd_valid <= 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         if (bus.mem_we && !bus.mem_en) note_fail("mem_we_without_en");
         if (bus.mem_en) begin
            if (exp_mem.size() == 0) note_fail("mem_en_unexpected");
            else begin
               mon_m = exp_mem.pop_front();
               check("mem_we", {31'b0, bus.mem_we}, {31'b0, mon_m.we});
               check("mem_addr", {17'b0, bus.mem_addr}, {17'b0, mon_m.addr});
               if (mon_m.we) check("mem_wdata", bus.mem_wdata, mon_m.wdata);
            end
         end
         if (bus.tx_start) begin
            tx_seen++;
            if (exp_tx.size() == 0) note_fail("tx_start_unexpected");
            else begin
               mon_b = exp_tx.pop_front();
               check("tx_byte", {24'b0, bus.tx_byte}, {24'b0, mon_b});
            end
         end
      end
   end

   task automatic issue(input logic rw, input logic [14:0] a, input logic [31:0] d,
                        input logic [1:0] e, output int t0);
      bus.cmd_rw = rw; bus.cmd_address = a; bus.cmd_data = d; bus.cmd_error = e;
      bus.cmd_done = 1'b1;
      @(negedge clock);
      t0 = cyc;
      bus.cmd_done = 1'b0;
   endtask

   task automatic wait_tx(input int t0, input int exp_lat, input string name);
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (bus.tx_start) begin
            found = 1;
            if (exp_lat >= 0) check(name, cyc - t0, exp_lat);
         end
      end
      if (!found) note_fail({name, "_timeout"});
   endtask

   task automatic wait_idle(input int budget, input string name);
      int i = 0;
      while (busy && i < budget) begin
         @(negedge clock);
         i++;
      end
      check(name, {31'b0, busy}, 32'd0);
   endtask

   task automatic drop_pulse();
      bus.cmd_rw = 1'b0; bus.cmd_address = 15'h0005; bus.cmd_data = 32'h5555_5555; bus.cmd_error = 2'b00;
      bus.cmd_done = 1'b1;
      @(negedge clock);
      bus.cmd_done = 1'b0;
      @(negedge clock);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check({tag, "_drop"}, {24'b0, drop_count}, 32'd0);
      check({tag, "_mem_en"}, {31'b0, bus.mem_en}, 32'd0);
      check({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
      check({tag, "_mem_addr"}, {17'b0, bus.mem_addr}, 32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      check({tag, "_tx_start"}, {31'b0, bus.tx_start}, 32'd0);
      check({tag, "_tx_byte"}, {24'b0, bus.tx_byte}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, seen0;
      bit got_done;
      bus.cmd_done = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_address = '0; bus.cmd_data = '0; bus.cmd_error = '0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clock);

      // write: frame 00
      expect_mem(1'b1, 15'h0012, 32'hDEADBEEF);
      exp_tx.push_back(8'h00);
      issue(1'b0, 15'h0012, 32'hDEADBEEF, 2'b00, t0);
      wait_tx(t0, 2, "lat_write");
      wait_idle(60, "write_idle");

      // read with three drops during the frame: 01 EF BE AD DE
      expect_mem(1'b0, 15'h0012, 32'h0);
      exp_tx.push_back(8'h01); exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
      exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
      issue(1'b1, 15'h0012, 32'h0, 2'b00, t0);
      wait_tx(t0, 4, "lat_read");
      repeat (3) drop_pulse();
      wait_idle(100, "read_idle");
      check("drop_after_read", {24'b0, drop_count}, 32'd3);

      // decoder error, plus a command on the DONE->IDLE edge that must be dropped
      exp_tx.push_back(8'hE2);
      issue(1'b0, 15'h0040, 32'h1111_1111, 2'b10, t0);
      wait_tx(t0, 1, "lat_error");
      got_done = 0;
      for (int i = 0; i < 20 && !got_done; i++) begin
         @(negedge clock);
         if (bus.tx_done) got_done = 1;
      end
      if (!got_done) note_fail("error_tx_done_timeout");
      @(negedge clock);
      check("done_state_busy", {31'b0, busy}, 32'd1);
      drop_pulse();
      check("drop_on_done_edge", {24'b0, drop_count}, 32'd4);
      check("idle_after_done", {31'b0, busy}, 32'd0);

      // max address write/read back, accepted right after IDLE
      expect_mem(1'b1, 15'h7FFF, 32'h12345678);
      exp_tx.push_back(8'h00);
      issue(1'b0, 15'h7FFF, 32'h12345678, 2'b00, t0);
      wait_tx(t0, 2, "lat_write_max");
      wait_idle(60, "write_max_idle");
      expect_mem(1'b0, 15'h7FFF, 32'h0);
      exp_tx.push_back(8'h01); exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
      exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
      issue(1'b1, 15'h7FFF, 32'h0, 2'b00, t0);
      wait_tx(t0, 4, "lat_read_max");
      wait_idle(100, "read_max_idle");

      // tx stall then tx_done withheld: only the status byte goes out
      force_busy = 1'b1;
      seen0 = tx_seen;
      expect_mem(1'b0, 15'h0012, 32'h0);
      exp_tx.push_back(8'h01);
      issue(1'b1, 15'h0012, 32'h0, 2'b00, t0);
      repeat (20) @(negedge clock);
      check("stall_no_tx", tx_seen, seen0);
      mute = 1'b1;
      force_busy = 1'b0;
      wait_tx(t0, -1, "stall_status");
      t1 = cyc;
      wait_idle(6000, "stall_idle");
      check("stall_elapsed", cyc - t1, DEF_TX_TIMEOUT + 2);
      repeat (10) @(negedge clock);
      check("stall_no_data", tx_seen, seen0 + 1);
      mute = 1'b0;

      // reset while parked in TX_DATA
      expect_mem(1'b0, 15'h7FFF, 32'h0);
      exp_tx.push_back(8'h01); exp_tx.push_back(8'h78);
      issue(1'b1, 15'h7FFF, 32'h0, 2'b00, t0);
      wait_tx(t0, 4, "lat_read_rst");
      wait_tx(t0, -1, "read_rst_byte0");
      force_busy = 1'b1;
      repeat (12) @(negedge clock);
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clock);
      check_all_zero("midreset");
      reset = 1'b1;
      force_busy = 1'b0;
      repeat (2) @(negedge clock);
      expect_mem(1'b1, 15'h0001, 32'hCAFEF00D);
      exp_tx.push_back(8'h00);
      issue(1'b0, 15'h0001, 32'hCAFEF00D, 2'b00, t0);
      wait_tx(t0, 2, "lat_write_after_reset");
      wait_idle(60, "final_idle");

      repeat (5) @(negedge clock);
      check("exp_tx_left", exp_tx.size(), 32'd0);
      check("exp_mem_left", exp_mem.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
